mdio_phy_model: RTL and testbench



---
 rtl/mdio_phy_model.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_mdio_phy_model.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_model.sv
// mdio_phy_model: Clause-22 MDIO management slave of one GbE PHY with a 32 x 16 register file.
// mdc/mdio are oversampled on clk; reads drive mdio through mdio_o/mdio_oe.
module mdio_phy_model #(
    parameter logic [4:0]  PHY_ADDR = 5'd0,
    parameter logic [15:0] PHYID1   = 16'h0141,
    parameter logic [15:0] PHYID2   = 16'h0CC2,
    parameter logic [15:0] CTRL_RST = 16'h1140
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phy_rstn,
    input  logic        link_up,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        wr_valid,
    output logic [4:0]  wr_reg,
    output logic [15:0] wr_data,
    output logic [7:0]  err_cnt
);

    // Status register value; bit 2 is replaced by the live link_up input.
    localparam logic [15:0] Reg1Default = 16'h7949;

    typedef enum logic [3:0] {
        StPreamble,
        StStart,
        StOp,
        StPhyad,
        StRegad,
        StTa,
        StWdata,
        StRdata,
        StSkip
    } state_e;

    logic [2:0]  mdc_q;
    logic [1:0]  mdio_q;
    logic        mdc_rise_q;
    logic        mdc_fall_q;
    logic        mdio_s;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [5:0]  pre_cnt_q;
    logic [15:0] shift_q;
    logic        is_rd_q;
    logic        match_q;
    logic [4:0]  regad_q;
    logic        soft_rst_q;
    logic [15:0] regs_q [32];

    logic        mdio_o_q;
    logic        mdio_oe_q;
    logic        wr_valid_q;
    logic [4:0]  wr_reg_q;
    logic [15:0] wr_data_q;
    logic [7:0]  err_cnt_q;

    logic [4:0]  rd_addr;
    logic [15:0] rd_val;
    logic [15:0] wr_word;
    logic [7:0]  err_inc;

    assign mdio_s = mdio_q[1];

    // Synchronise mdc/mdio and derive one-cycle edge strobes; strobes are masked in PHY reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdc_q      <= 3'b000;
            mdio_q     <= 2'b11;
            mdc_rise_q <= 1'b0;
            mdc_fall_q <= 1'b0;
        end else begin
            mdc_q      <= {mdc_q[1:0], mdc};
            mdio_q     <= {mdio_q[0], mdio_i};
            mdc_rise_q <= phy_rstn & mdc_q[1] & ~mdc_q[2];
            mdc_fall_q <= phy_rstn & ~mdc_q[1] & mdc_q[2];
        end
    end

    // Read mux over the address being completed on this REGAD bit, plus write word assembly
    always_comb begin
        rd_addr = {shift_q[3:0], mdio_s};
        rd_val  = regs_q[rd_addr];
        case (rd_addr)
            5'd1:    rd_val = {Reg1Default[15:3], link_up, Reg1Default[1:0]};
            5'd2:    rd_val = PHYID1;
            5'd3:    rd_val = PHYID2;
            default: ;
        endcase
        wr_word = {shift_q[14:0], mdio_s};
        err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end

    // Frame decoder, register file and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StPreamble;
            cnt_q      <= 5'd0;
            pre_cnt_q  <= 6'd0;
            shift_q    <= 16'h0000;
            is_rd_q    <= 1'b0;
            match_q    <= 1'b0;
            regad_q    <= 5'd0;
            soft_rst_q <= 1'b0;
            mdio_o_q   <= 1'b1;
            mdio_oe_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_reg_q   <= 5'd0;
            wr_data_q  <= 16'h0000;
            err_cnt_q  <= 8'd0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 16'h0000;
            end
            regs_q[0] <= CTRL_RST;
        end else begin
            wr_valid_q <= 1'b0;
            soft_rst_q <= 1'b0;
            if (!phy_rstn || soft_rst_q) begin
                for (int i = 0; i < 32; i++) begin
                    regs_q[i] <= 16'h0000;
                end
                regs_q[0] <= CTRL_RST;
            end
            if (!phy_rstn) begin
                // Hardware reset: abandon the frame and release the bus, keep err_cnt
                state_q   <= StPreamble;
                cnt_q     <= 5'd0;
                pre_cnt_q <= 6'd0;
                shift_q   <= 16'h0000;
                is_rd_q   <= 1'b0;
                match_q   <= 1'b0;
                regad_q   <= 5'd0;
                mdio_o_q  <= 1'b1;
                mdio_oe_q <= 1'b0;
                wr_reg_q  <= 5'd0;
                wr_data_q <= 16'h0000;
            end else if (mdc_rise_q) begin
                case (state_q)
                    StPreamble: begin
                        if (mdio_s) begin
                            if (pre_cnt_q != 6'd32) pre_cnt_q <= pre_cnt_q + 6'd1;
                        end else if (pre_cnt_q == 6'd32) begin
                            state_q   <= StStart;
                            pre_cnt_q <= 6'd0;
                        end else begin
                            pre_cnt_q <= 6'd0;
                        end
                    end
                    StStart: begin
                        if (mdio_s) begin
                            state_q <= StOp;
                            cnt_q   <= 5'd0;
                        end else begin
                            err_cnt_q <= err_inc;
                            state_q   <= StPreamble;
                        end
                    end
                    StOp: begin
                        if (cnt_q == 5'd0) begin
                            shift_q[0] <= mdio_s;
                            cnt_q      <= 5'd1;
                        end else begin
                            cnt_q <= 5'd0;
                            if ({shift_q[0], mdio_s} == 2'b10) begin
                                is_rd_q <= 1'b1;
                                state_q <= StPhyad;
                            end else if ({shift_q[0], mdio_s} == 2'b01) begin
                                is_rd_q <= 1'b0;
                                state_q <= StPhyad;
                            end else begin
                                err_cnt_q <= err_inc;
                                state_q   <= StPreamble;
                            end
                        end
                    end
                    StPhyad: begin
                        shift_q <= {shift_q[14:0], mdio_s};
                        if (cnt_q == 5'd4) begin
                            match_q <= ({shift_q[3:0], mdio_s} == PHY_ADDR);
                            cnt_q   <= 5'd0;
                            state_q <= StRegad;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    StRegad: begin
                        shift_q <= {shift_q[14:0], mdio_s};
                        if (cnt_q == 5'd4) begin
                            regad_q <= rd_addr;
                            cnt_q   <= 5'd0;
                            if (match_q) begin
                                state_q <= StTa;
                                if (is_rd_q) shift_q <= rd_val;
                            end else begin
                                state_q <= StSkip;
                            end
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    StTa: begin
                        // Read turnaround is paced by falling edges instead
                        if (!is_rd_q) begin
                            if (cnt_q == 5'd1) begin
                                cnt_q   <= 5'd0;
                                state_q <= StWdata;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                    end
                    StWdata: begin
                        shift_q <= wr_word;
                        if (cnt_q == 5'd15) begin
                            wr_valid_q <= 1'b1;
                            wr_reg_q   <= regad_q;
                            wr_data_q  <= wr_word;
                            if (regad_q == 5'd0 || regad_q > 5'd3) regs_q[regad_q] <= wr_word;
                            if (regad_q == 5'd0 && wr_word[15]) soft_rst_q <= 1'b1;
                            cnt_q     <= 5'd0;
                            pre_cnt_q <= 6'd0;
                            state_q   <= StPreamble;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    StSkip: begin
                        if (cnt_q == 5'd17) begin
                            cnt_q     <= 5'd0;
                            pre_cnt_q <= 6'd0;
                            state_q   <= StPreamble;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (mdc_fall_q) begin
                case (state_q)
                    StTa: begin
                        if (is_rd_q) begin
                            if (cnt_q == 5'd0) begin
                                cnt_q <= 5'd1;
                            end else begin
                                cnt_q     <= 5'd0;
                                mdio_oe_q <= 1'b1;
                                mdio_o_q  <= 1'b0;
                                state_q   <= StRdata;
                            end
                        end
                    end
                    StRdata: begin
                        if (cnt_q == 5'd16) begin
                            mdio_oe_q <= 1'b0;
                            mdio_o_q  <= 1'b1;
                            cnt_q     <= 5'd0;
                            pre_cnt_q <= 6'd0;
                            state_q   <= StPreamble;
                        end else begin
                            mdio_o_q <= shift_q[15];
                            shift_q  <= {shift_q[14:0], 1'b0};
                            cnt_q    <= cnt_q + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mdio_o   = mdio_o_q;
    assign mdio_oe  = mdio_oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_reg   = wr_reg_q;
    assign wr_data  = wr_data_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mdio_phy_model.sv
// tb_mdio_phy_model: directed MDIO master with read/write scoreboards for mdio_phy_model.
module tb_mdio_phy_model;

    localparam int Half = 80;

    logic        clk;
    logic        reset;
    logic        phy_rstn;
    logic        link_up;
    logic        mdc;
    logic        mdio_line;
    logic        mdio_o;
    logic        mdio_oe;
    logic        wr_valid;
    logic [4:0]  wr_reg;
    logic [15:0] wr_data;
    logic [7:0]  err_cnt;

    logic        m_oe;
    logic        m_val;

    int total;
    int bad;
    int wr_cnt;
    int oe_bits;
    logic oe_seen;
    logic prev_wv;

    logic [15:0] exp_rd_q [$];
    logic [20:0] exp_wr_q [$];

    // PHY drive wins, then master drive, else pull-up
    assign mdio_line = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

    mdio_phy_model dut (
        .clk      (clk),
        .reset    (reset),
        .phy_rstn (phy_rstn),
        .link_up  (link_up),
        .mdc      (mdc),
        .mdio_i   (mdio_line),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .wr_valid (wr_valid),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: pops the write scoreboard on each wr_valid pulse
    always @(negedge clk) begin
        if (mdio_oe) oe_seen = 1'b1;
        if (wr_valid) begin
            wr_cnt++;
            check("wr_pulse_width", {31'd0, prev_wv}, 32'd0);
            check("wr_queue_nonempty", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) begin
                logic [20:0] e;
                e = exp_wr_q.pop_front();
                check("wr_reg_data", {11'd0, wr_reg, wr_data}, {11'd0, e});
            end
        end
        prev_wv = wr_valid;
    end

    task automatic mdc_bit(input logic v, input logic drv, output logic s);
        m_val = v;
        m_oe  = drv;
        #Half;
        s = mdio_line;
        if (mdio_oe) oe_bits++;
        mdc = 1'b1;
        #Half;
        mdc = 1'b0;
    endtask

    // Frame bits 31..last after pre preamble ones; read frames release TA/data and capture data
    task automatic mdio_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                              input logic [4:0] ra, input logic [15:0] wd, input int last,
                              output logic [15:0] rd);
        logic [31:0] hdr;
        logic s;
        hdr = {2'b01, op, pa, ra, 2'b10, wd};
        rd = 16'h0000;
        oe_bits = 0;
        for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, s);
        for (int i = 31; i >= last; i--) begin
            if (op == 2'b10 && i <= 17) begin
                mdc_bit(1'b1, 1'b0, s);
                if (i <= 15) rd[i] = s;
            end else begin
                mdc_bit(hdr[i], 1'b1, s);
            end
        end
        m_oe = 1'b0;
    endtask

    task automatic do_write(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] wd, input logic acked);
        logic [15:0] rd;
        if (acked) exp_wr_q.push_back({ra, wd});
        mdio_frame(pre, 2'b01, pa, ra, wd, 0, rd);
        #200;
    endtask

    task automatic do_read(input logic [4:0] ra, input logic [15:0] exp, input string tag);
        logic [15:0] rd;
        logic [15:0] e;
        exp_rd_q.push_back(exp);
        mdio_frame(32, 2'b10, 5'd0, ra, 16'h0000, 0, rd);
        e = exp_rd_q.pop_front();
        check(tag, {16'd0, rd}, {16'd0, e});
        check({tag, "_oe_bits"}, oe_bits, 32'd17);
        #200;
        check({tag, "_oe_released"}, {31'd0, mdio_oe}, 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        int wr_before;
        total    = 0;
        bad      = 0;
        wr_cnt   = 0;
        oe_bits  = 0;
        oe_seen  = 1'b0;
        prev_wv  = 1'b0;
        reset    = 1'b1;
        phy_rstn = 1'b1;
        link_up  = 1'b0;
        mdc      = 1'b0;
        m_oe     = 1'b0;
        m_val    = 1'b1;
        #20 reset = 1'b0;
        #30;

        check("rst_mdio_o", {31'd0, mdio_o}, 32'd1);
        check("rst_mdio_oe", {31'd0, mdio_oe}, 32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_wr_reg", {27'd0, wr_reg}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Basic write then read-back
        do_write(32, 5'd0, 5'd16, 16'hA5C3, 1'b1);
        check("wr16_count", wr_cnt, 32'd1);
        do_read(5'd16, 16'hA5C3, "rd16");

        // ID registers are read-only
        do_read(5'd2, 16'h0141, "rd_id1");
        do_read(5'd3, 16'h0CC2, "rd_id2");
        do_write(32, 5'd0, 5'd2, 16'hFFFF, 1'b1);
        check("wr_id1_count", wr_cnt, 32'd2);
        do_read(5'd2, 16'h0141, "rd_id1_after_wr");

        // Status register link bit
        link_up = 1'b0;
        do_read(5'd1, 16'h7949, "rd_stat_down");
        link_up = 1'b1;
        do_read(5'd1, 16'h794D, "rd_stat_up");

        // Other PHY address: no drive, no write
        oe_seen = 1'b0;
        mdio_frame(32, 2'b10, 5'd3, 5'd16, 16'h0000, 0, rd);
        #200;
        check("pa3_rd_oe_bits", oe_bits, 32'd0);
        check("pa3_rd_oe_seen", {31'd0, oe_seen}, 32'd0);
        wr_before = wr_cnt;
        do_write(32, 5'd3, 5'd16, 16'hBEEF, 1'b0);
        check("pa3_wr_ignored", wr_cnt, wr_before);
        do_read(5'd16, 16'hA5C3, "rd16_after_pa3");

        // Short preamble is ignored without an error
        wr_before = wr_cnt;
        do_write(31, 5'd0, 5'd16, 16'h1234, 1'b0);
        check("short_pre_ignored", wr_cnt, wr_before);
        check("short_pre_err", {24'd0, err_cnt}, 32'd0);
        do_read(5'd16, 16'hA5C3, "rd16_after_short");

        // Illegal opcode
        mdio_frame(32, 2'b11, 5'd0, 5'd16, 16'h0000, 0, rd);
        #200;
        check("op11_err_cnt", {24'd0, err_cnt}, 32'd1);
        do_read(5'd16, 16'hA5C3, "rd16_after_op11");

        // Soft reset restores defaults
        do_write(32, 5'd0, 5'd0, 16'h8000, 1'b1);
        do_read(5'd16, 16'h0000, "rd16_after_softrst");
        do_read(5'd0, 16'h1140, "rd0_after_softrst");

        // Hardware reset in the middle of a read
        do_write(32, 5'd0, 5'd16, 16'h5A5A, 1'b1);
        mdio_frame(32, 2'b10, 5'd0, 5'd16, 16'h0000, 10, rd);
        check("abort_oe_before", {31'd0, mdio_oe}, 32'd1);
        check("abort_partial_data", {26'd0, rd[15:10]}, 32'h16);
        phy_rstn = 1'b0;
        @(posedge clk);
        #1;
        check("abort_oe_dropped", {31'd0, mdio_oe}, 32'd0);
        check("abort_mdio_o_high", {31'd0, mdio_o}, 32'd1);
        #100;
        check("abort_err_kept", {24'd0, err_cnt}, 32'd1);
        check("abort_wr_reg_cleared", {27'd0, wr_reg}, 32'd0);
        phy_rstn = 1'b1;
        #200;
        do_read(5'd16, 16'h0000, "rd16_after_hwrst");
        check("final_wr_count", wr_cnt, 32'd4);

        check("wr_queue_drained", exp_wr_q.size(), 32'd0);
        check("rd_queue_drained", exp_rd_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
